// File: rtl/hps_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : hps_frame_reader
// Purpose  : Multi-channel ADC frame readout towards the HPS. Waits until
//            every enabled channel FIFO (show-ahead) holds a full frame, then
//            drains each enabled channel in ascending index order through a
//            paced valid/ready word interface. Single-shot or continuous.
// Ports    : clk, reset (sync, active-high)
//            KEY (active-low arm), hps_read_rq (level arm), mode, ch_mask,
//            rd_div (pacing: one read opportunity every rd_div+1 cycles)
//            fifo_q / fifo_usedw / fifo_empty in, fifo_rdreq (one-hot pop) out
//            hps_word / hps_ch / hps_valid out, hps_ready in
//            hps_read_status, short_frame (sticky), frame_count (wrapping)
// Options  : HPS_FRAME_TAG_EN - when defined, the channel index is also placed
//            in the top CH_W bits of hps_word.
// Revision : 1.0 - initial release
// ============================================================================
module hps_frame_reader #(
    parameter int DATA_W      = 12,
    parameter int WORD_W      = 16,
    parameter int NUM_CH      = 2,
    parameter int EXPONENT    = 8,
    parameter int FRAME_WORDS = 255,
    parameter int RDIV_W      = 4,
    parameter int CH_W        = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       KEY,
    input  logic                       hps_read_rq,
    input  logic                       mode,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [RDIV_W-1:0]          rd_div,
    input  logic [NUM_CH*DATA_W-1:0]   fifo_q,
    input  logic [NUM_CH*EXPONENT-1:0] fifo_usedw,
    input  logic [NUM_CH-1:0]          fifo_empty,
    output logic [NUM_CH-1:0]          fifo_rdreq,
    output logic [WORD_W-1:0]          hps_word,
    output logic [CH_W-1:0]            hps_ch,
    output logic                       hps_valid,
    input  logic                       hps_ready,
    output logic                       hps_read_status,
    output logic                       short_frame,
    output logic [15:0]                frame_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FULL = 3'd1,
        S_SELECT    = 3'd2,
        S_READ      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [EXPONENT-1:0] c_frame_words = EXPONENT'(FRAME_WORDS);

    // Elaboration-time sanity checks on the configuration
    if (WORD_W < DATA_W) begin : g_word_width_check
        $error("hps_frame_reader: WORD_W must be >= DATA_W");
    end
    if ((1 << CH_W) < NUM_CH) begin : g_ch_width_check
        $error("hps_frame_reader: CH_W too narrow for NUM_CH");
    end
`ifdef HPS_FRAME_TAG_EN
    if ((WORD_W - DATA_W) < CH_W) begin : g_tag_width_check
        $error("hps_frame_reader: no room for channel tag in hps_word");
    end
`endif

    state_t              r_state;
    state_t              w_next;
    logic [RDIV_W-1:0]   r_pace;
    logic [CH_W-1:0]     r_ch;
    logic [EXPONENT-1:0] r_wcnt;
    logic [NUM_CH-1:0]   r_pending;   // channels of this frame not yet served
    logic                r_mode;

    logic                w_arm;
    logic                w_all_full;
    logic                w_tick;
    logic                w_cur_empty;
    logic [DATA_W-1:0]   w_sample;
    logic [WORD_W-1:0]   w_word;
    logic [CH_W-1:0]     w_pick_ch;
    logic                w_pick_any;
    logic                w_load;
    logic                w_short;

    assign w_arm       = (~KEY | hps_read_rq) & (|ch_mask);
    assign w_tick      = (r_state == S_READ) && (r_pace == '0);
    assign w_cur_empty = fifo_empty[r_ch];
    assign w_sample    = fifo_q[r_ch*DATA_W +: DATA_W];
    assign w_pick_any  = |r_pending;

    assign hps_read_status = (r_state == S_SELECT) || (r_state == S_READ);

`ifdef HPS_FRAME_TAG_EN
    always_comb begin
        w_word = WORD_W'(w_sample);
        w_word[WORD_W-1 -: CH_W] = r_ch;
    end
`else
    assign w_word = WORD_W'(w_sample);
`endif

    // Disabled channels are ignored when deciding that a frame is available
    always_comb begin
        w_all_full = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_mask[i] && (fifo_usedw[i*EXPONENT +: EXPONENT] < c_frame_words)) begin
                w_all_full = 1'b0;
            end
        end
    end

    // Lowest pending index wins: scan downwards so the last hit is the lowest
    always_comb begin
        w_pick_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_short = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arm) begin
                    w_next = S_WAIT_FULL;
                end
            end
            S_WAIT_FULL: begin
                if (w_all_full) begin
                    w_next = S_SELECT;
                end
            end
            S_SELECT: begin
                w_next = w_pick_any ? S_READ : S_DONE;
            end
            S_READ: begin
                if (hps_valid) begin
                    // A word is pending: nothing else may happen until it is taken
                    if (hps_ready && (r_wcnt == c_frame_words)) begin
                        w_next = S_SELECT;
                    end
                end else if (r_wcnt >= c_frame_words) begin
                    w_next = S_SELECT;
                end else if (w_cur_empty) begin
                    w_short = 1'b1;
                    w_next  = S_SELECT;
                end else if (w_tick) begin
                    w_load = 1'b1;
                end
            end
            S_DONE: begin
                w_next = (r_mode && w_arm) ? S_WAIT_FULL : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pace      <= '0;
            r_ch        <= '0;
            r_wcnt      <= '0;
            r_pending   <= '0;
            r_mode      <= 1'b0;
            fifo_rdreq  <= '0;
            hps_word    <= '0;
            hps_ch      <= '0;
            hps_valid   <= 1'b0;
            short_frame <= 1'b0;
            frame_count <= '0;
        end else begin
            fifo_rdreq <= '0;

            // Pacing counter is parked at zero outside READ so the first
            // READ cycle is already a read opportunity.
            if (r_state == S_READ) begin
                r_pace <= (r_pace == '0) ? rd_div : r_pace - 1'b1;
            end else begin
                r_pace <= '0;
            end

            if ((r_state == S_IDLE) && w_arm) begin
                short_frame <= 1'b0;
            end

            // Frame configuration is frozen when the frame starts
            if ((r_state == S_WAIT_FULL) && w_all_full) begin
                r_pending <= ch_mask;
                r_mode    <= mode;
            end

            if ((r_state == S_SELECT) && w_pick_any) begin
                r_ch      <= w_pick_ch;
                r_pending <= r_pending & ~(NUM_CH'(1) << w_pick_ch);
                r_wcnt    <= '0;
            end

            // The pop is issued one cycle after capture; for a show-ahead
            // FIFO this removes exactly the word just latched.
            if (w_load) begin
                hps_word   <= w_word;
                hps_ch     <= r_ch;
                hps_valid  <= 1'b1;
                fifo_rdreq <= NUM_CH'(1) << r_ch;
                r_wcnt     <= r_wcnt + 1'b1;
            end else if (hps_valid && hps_ready) begin
                hps_valid <= 1'b0;
            end

            if (w_short) begin
                short_frame <= 1'b1;
            end

            if (r_state == S_DONE) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hps_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_frame_reader
// Purpose  : Self-checking bench for hps_frame_reader. Behavioural FIFOs feed
//            the DUT; a queue-based frame model predicts the word stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_frame_reader;

    localparam int DATA_W      = 12;
    localparam int WORD_W      = 16;
    localparam int NUM_CH      = 2;
    localparam int EXPONENT    = 8;
    localparam int FRAME_WORDS = 4;
    localparam int RDIV_W      = 4;
    localparam int CH_W        = 1;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       KEY;
    logic                       hps_read_rq;
    logic                       mode;
    logic [NUM_CH-1:0]          ch_mask;
    logic [RDIV_W-1:0]          rd_div;
    logic [NUM_CH*DATA_W-1:0]   fifo_q;
    logic [NUM_CH*EXPONENT-1:0] fifo_usedw;
    logic [NUM_CH-1:0]          fifo_empty;
    logic [NUM_CH-1:0]          fifo_rdreq;
    logic [WORD_W-1:0]          hps_word;
    logic [CH_W-1:0]            hps_ch;
    logic                       hps_valid;
    logic                       hps_ready;
    logic                       hps_read_status;
    logic                       short_frame;
    logic [15:0]                frame_count;

    hps_frame_reader #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .NUM_CH(NUM_CH), .EXPONENT(EXPONENT),
        .FRAME_WORDS(FRAME_WORDS), .RDIV_W(RDIV_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .KEY(KEY), .hps_read_rq(hps_read_rq),
        .mode(mode), .ch_mask(ch_mask), .rd_div(rd_div), .fifo_q(fifo_q),
        .fifo_usedw(fifo_usedw), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
        .hps_word(hps_word), .hps_ch(hps_ch), .hps_valid(hps_valid),
        .hps_ready(hps_ready), .hps_read_status(hps_read_status),
        .short_frame(short_frame), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural FIFOs and shadow copies for the model
    logic [DATA_W-1:0] fq0[$];
    logic [DATA_W-1:0] fq1[$];
    logic [DATA_W-1:0] sh0[$];
    logic [DATA_W-1:0] sh1[$];
    int                phantom[NUM_CH];

    task automatic refresh_fifo();
        fifo_q[0 +: DATA_W]          = (fq0.size() > 0) ? fq0[0] : '0;
        fifo_q[DATA_W +: DATA_W]     = (fq1.size() > 0) ? fq1[0] : '0;
        fifo_usedw[0 +: EXPONENT]    = EXPONENT'(fq0.size() + phantom[0]);
        fifo_usedw[EXPONENT +: EXPONENT] = EXPONENT'(fq1.size() + phantom[1]);
        fifo_empty[0] = (fq0.size() == 0);
        fifo_empty[1] = (fq1.size() == 0);
    endtask

    task automatic push_word(input int c, input logic [DATA_W-1:0] d);
        if (c == 0) begin fq0.push_back(d); sh0.push_back(d); end
        else        begin fq1.push_back(d); sh1.push_back(d); end
        refresh_fifo();
    endtask

    task automatic clear_fifos();
        fq0.delete(); fq1.delete(); sh0.delete(); sh1.delete();
        phantom[0] = 0; phantom[1] = 0;
        refresh_fifo();
    endtask

    // ---------------- frame model: expected {ch, word} stream
    logic [31:0] exp_q[$];
    logic        exp_short;

    function automatic logic [31:0] expect_word(input int c, input logic [DATA_W-1:0] d);
        logic [31:0] r;
        r = '0;
        r[WORD_W-1:0] = WORD_W'(d);
`ifdef HPS_FRAME_TAG_EN
        r[WORD_W-1 -: CH_W] = CH_W'(c);
`endif
        r[WORD_W +: CH_W] = CH_W'(c);
        return r;
    endfunction

    // A frame takes up to FRAME_WORDS words from each enabled channel, in
    // ascending channel order; running out early marks a short frame.
    task automatic predict_frame(input logic [NUM_CH-1:0] m);
        int n;
        for (int c = 0; c < NUM_CH; c++) begin
            n = 0;
            if (m[c]) begin
                while (n < FRAME_WORDS && ((c == 0) ? sh0.size() : sh1.size()) > 0) begin
                    if (c == 0) exp_q.push_back(expect_word(c, sh0.pop_front()));
                    else        exp_q.push_back(expect_word(c, sh1.pop_front()));
                    n++;
                end
                if (n < FRAME_WORDS) exp_short = 1'b1;
            end
        end
    endtask

    // ---------------- HPS ready driver
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    initial begin
        hps_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       hps_ready = 1'b1;
                1:       hps_ready = ($urandom_range(0, 3) != 0);
                default: hps_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor: protocol checks, scoreboard, FIFO pops
    int              cyc = 0;
    int              rd_total = 0;
    int              hs_total = 0;
    int              hs_cyc[$];
    int              last_rd_cyc = -1;
    int              last_rd_ch = 0;
    int              last_gap = 0;
    logic            prev_v = 1'b0;
    logic            prev_r = 1'b0;
    logic [WORD_W-1:0] prev_w = '0;
    logic [CH_W-1:0] prev_c = '0;

    initial begin
        int ch;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_v = 1'b0;
                last_rd_cyc = -1;
            end else begin
                check_eq("rdreq_onehot", 32'($onehot0(fifo_rdreq)), 1);
                check_eq("rdreq_to_empty", 32'(fifo_rdreq & fifo_empty), 0);
                if (fifo_rdreq != '0) begin
                    check_eq("rdreq_while_pending", 32'(prev_v), 0);
                    rd_total++;
                    ch = fifo_rdreq[1] ? 1 : 0;
                    if (last_rd_cyc >= 0 && last_rd_ch == ch) begin
                        last_gap = cyc - last_rd_cyc;
                        check_eq("rdreq_spacing", 32'(last_gap >= int'(rd_div) + 1), 1);
                    end
                    last_rd_cyc = cyc;
                    last_rd_ch  = ch;
                end
                if (prev_v && !prev_r) begin
                    check_eq("valid_hold", 32'(hps_valid), 1);
                    check_eq("word_hold", 32'(hps_word), 32'(prev_w));
                    check_eq("ch_hold", 32'(hps_ch), 32'(prev_c));
                end
                if (hps_valid && hps_ready) begin
                    hs_total++;
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0)
                        check_eq("unexpected_word", {15'd0, hps_ch, hps_word}, 32'hFFFF_FFFF);
                    else
                        check_eq("word", {15'd0, hps_ch, hps_word}, exp_q.pop_front());
                end
                if (fifo_rdreq[0] && fq0.size() > 0) void'(fq0.pop_front());
                if (fifo_rdreq[1] && fq1.size() > 0) void'(fq1.pop_front());
                refresh_fifo();
                prev_v = hps_valid;
                prev_r = hps_ready;
                prev_w = hps_word;
                prev_c = hps_ch;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_key();
        KEY = 1'b0;
        step(1);
        KEY = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frame_count != 16'(target) && n < budget) begin step(1); n++; end
        check_eq("frame_count", 32'(frame_count), 32'(target));
    endtask

    task automatic load_both(input int n0, input int n1);
        logic [DATA_W-1:0] b0, b1;
        b0 = DATA_W'($urandom);
        b1 = DATA_W'($urandom);
        for (int i = 0; i < n0; i++) push_word(0, b0 + DATA_W'(i));
        for (int i = 0; i < n1; i++) push_word(1, b1 + DATA_W'(i));
    endtask

    // ---------------- main sequence
    initial begin
        int hs0, rd0, n, fc;
        logic [WORD_W-1:0] w0;
        logic [CH_W-1:0]   c0;
        logic [NUM_CH-1:0] m;

        reset = 1'b1; KEY = 1'b1; hps_read_rq = 1'b0; mode = 1'b0;
        ch_mask = '0; rd_div = '0;
        exp_short = 1'b0;
        clear_fifos();
        step(3);
        check_eq("rst_valid", 32'(hps_valid), 0);
        check_eq("rst_rdreq", 32'(fifo_rdreq), 0);
        check_eq("rst_word", 32'(hps_word), 0);
        check_eq("rst_ch", 32'(hps_ch), 0);
        check_eq("rst_status", 32'(hps_read_status), 0);
        check_eq("rst_short", 32'(short_frame), 0);
        check_eq("rst_fcount", 32'(frame_count), 0);
        reset = 1'b0;
        step(2);

        // Basic two-channel frame at full rate
        ch_mask = 2'b11; rd_div = '0; rdy_mode = 0;
        load_both(4, 4);
        exp_short = 1'b0; predict_frame(ch_mask);
        hs0 = hs_total;
        pulse_key();
        wait_frames(1, 200);
        step(3);
        check_eq("t1_transfers", 32'(hs_total - hs0), 8);
        if (hs_total - hs0 == 8)
            check_eq("t1_span", 32'(hs_cyc[hs0 + 7] - hs_cyc[hs0]), 15);
        check_eq("t1_status", 32'(hps_read_status), 0);
        check_eq("t1_short", 32'(short_frame), 32'(exp_short));
        check_eq("t1_exp_left", 32'(exp_q.size()), 0);

        // HPS stalls for 10 cycles on the first word
        rdy_mode = 2;
        load_both(4, 4);
        exp_short = 1'b0; predict_frame(ch_mask);
        pulse_key();
        n = 0;
        while (!hps_valid && n < 100) begin step(1); n++; end
        check_eq("t2_valid_seen", 32'(hps_valid), 1);
        @(negedge clk); #1;
        w0 = hps_word; c0 = hps_ch; rd0 = rd_total;
        step(10);
        check_eq("t2_valid_held", 32'(hps_valid), 1);
        check_eq("t2_word_held", 32'(hps_word), 32'(w0));
        check_eq("t2_ch_held", 32'(hps_ch), 32'(c0));
        check_eq("t2_no_pop", 32'(rd_total), 32'(rd0));
        rdy_mode = 0;
        wait_frames(2, 300);
        step(3);
        check_eq("t2_exp_left", 32'(exp_q.size()), 0);

        // Paced reads
        rd_div = 4'd3;
        load_both(4, 4);
        exp_short = 1'b0; predict_frame(ch_mask);
        hs0 = hs_total;
        pulse_key();
        wait_frames(3, 400);
        step(3);
        check_eq("t3_transfers", 32'(hs_total - hs0), 8);
        check_eq("t3_gap", 32'(last_gap), 4);

        // Only channel 1 enabled
        rd_div = '0; ch_mask = 2'b10;
        load_both(4, 4);
        exp_short = 1'b0; predict_frame(ch_mask);
        hs0 = hs_total;
        pulse_key();
        wait_frames(4, 200);
        step(3);
        check_eq("t4_transfers", 32'(hs_total - hs0), 4);
        check_eq("t4_ch0_untouched", 32'(fq0.size()), 4);
        check_eq("t4_exp_left", 32'(exp_q.size()), 0);
        clear_fifos();

        // No channel enabled: request must be ignored
        ch_mask = '0; hps_read_rq = 1'b1;
        load_both(4, 4);
        rd0 = rd_total;
        step(20);
        check_eq("t5_no_pop", 32'(rd_total), 32'(rd0));
        check_eq("t5_status", 32'(hps_read_status), 0);
        check_eq("t5_fcount", 32'(frame_count), 4);
        hps_read_rq = 1'b0;
        step(1);
        clear_fifos();

        // Continuous capture: three frames, request dropped during the third
        ch_mask = 2'b11; mode = 1'b1; rdy_mode = 1;
        rd_div = RDIV_W'($urandom_range(0, 2));
        load_both(12, 12);
        exp_short = 1'b0;
        for (int f = 0; f < 3; f++) predict_frame(ch_mask);
        hs0 = hs_total;
        hps_read_rq = 1'b1;
        wait_frames(6, 1000);
        n = 0;
        while (!hps_read_status && n < 20) begin step(1); n++; end
        check_eq("t6_third_started", 32'(hps_read_status), 1);
        hps_read_rq = 1'b0;
        wait_frames(7, 500);
        load_both(4, 4);
        rd0 = rd_total;
        step(30);
        check_eq("t6_transfers", 32'(hs_total - hs0), 24);
        check_eq("t6_idle_no_pop", 32'(rd_total), 32'(rd0));
        check_eq("t6_status", 32'(hps_read_status), 0);
        check_eq("t6_exp_left", 32'(exp_q.size()), 0);
        mode = 1'b0;
        clear_fifos();

        // Channel 0 runs dry after two words
        rd_div = '0;
        load_both(2, 4);
        phantom[0] = 2; refresh_fifo();
        exp_short = 1'b0; predict_frame(ch_mask);
        hs0 = hs_total;
        pulse_key();
        wait_frames(8, 400);
        step(3);
        check_eq("t7_short", 32'(short_frame), 32'(exp_short));
        check_eq("t7_transfers", 32'(hs_total - hs0), 6);
        check_eq("t7_exp_left", 32'(exp_q.size()), 0);
        clear_fifos();

        // Randomized single-shot frames, some of them short
        fc = 8;
        for (int it = 0; it < 8; it++) begin
            m = NUM_CH'($urandom_range(1, 3));
            ch_mask = m;
            rd_div = RDIV_W'($urandom_range(0, 3));
            rdy_mode = int'($urandom_range(0, 1));
            load_both(int'($urandom_range(FRAME_WORDS - 2, FRAME_WORDS)),
                      int'($urandom_range(FRAME_WORDS - 2, FRAME_WORDS)));
            phantom[0] = FRAME_WORDS - fq0.size();
            phantom[1] = FRAME_WORDS - fq1.size();
            refresh_fifo();
            exp_short = 1'b0; predict_frame(m);
            if ($urandom_range(0, 1) == 1) begin
                pulse_key();
            end else begin
                hps_read_rq = 1'b1; step(1); hps_read_rq = 1'b0;
            end
            fc++;
            wait_frames(fc, 600);
            step(3);
            check_eq("rnd_short", 32'(short_frame), 32'(exp_short));
            check_eq("rnd_exp_left", 32'(exp_q.size()), 0);
            check_eq("rnd_status", 32'(hps_read_status), 0);
            clear_fifos();
        end

        // Reset in the middle of a frame
        ch_mask = 2'b11; rd_div = 4'd1; rdy_mode = 0;
        load_both(4, 4);
        exp_short = 1'b0; predict_frame(ch_mask);
        hs0 = hs_total;
        pulse_key();
        n = 0;
        while (hs_total < hs0 + 3 && n < 200) begin step(1); n++; end
        check_eq("t8_mid_frame", 32'(hps_read_status), 1);
        reset = 1'b1;
        step(1);
        check_eq("t8_valid", 32'(hps_valid), 0);
        check_eq("t8_rdreq", 32'(fifo_rdreq), 0);
        check_eq("t8_word", 32'(hps_word), 0);
        check_eq("t8_status", 32'(hps_read_status), 0);
        check_eq("t8_fcount", 32'(frame_count), 0);
        exp_q.delete();
        rd0 = rd_total;
        step(1);
        reset = 1'b0;
        step(20);
        check_eq("t8_no_pop", 32'(rd_total), 32'(rd0));
        check_eq("t8_idle_valid", 32'(hps_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
